// File: rtl/wb_slave_mem_bfm.sv
// Wishbone classic-cycle slave backed by a word-addressed internal memory.
// Each request accepted in IDLE is answered after a fixed number of wait
// states with a single-cycle registered ACK (in-window) or ERR (out-of-window).
//
// Optional feature macro: WB_SLAVE_MEM_RAND_WAIT_EN
//   When defined, a 16-bit Galois LFSR adds 0..3 extra wait states per access.
//
// Ports:
//   clk    - clock
//   rstn   - synchronous active-low reset (memory contents are not reset)
//   ADR    - byte address
//   DAT_W  - write data
//   DAT_R  - read data, held until the next read response
//   CYC    - bus cycle active
//   STB    - strobe / request valid
//   WE     - 1 = write, 0 = read
//   SEL    - byte-lane enables
//   ACK    - normal termination
//   ERR    - error termination
module wb_slave_mem_bfm #(
  parameter int unsigned              WB_ADDR_WIDTH  = 32,
  parameter int unsigned              WB_DATA_WIDTH  = 32,  // 8, 16, 32 or 64
  parameter int unsigned              MEM_DEPTH_LOG2 = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,  // aligned to window size
  parameter int unsigned              WAIT_STATES    = 0    // 0..15
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int unsigned NumBytes = WB_DATA_WIDTH / 8;
  localparam int unsigned Bl       = $clog2(NumBytes);
  localparam int unsigned WinBits  = MEM_DEPTH_LOG2 + Bl;
  localparam int unsigned Depth    = 1 << MEM_DEPTH_LOG2;
  localparam logic [WB_ADDR_WIDTH-1:0] WinMask =
      ~((WB_ADDR_WIDTH'(1) << WinBits) - WB_ADDR_WIDTH'(1));

`ifdef WB_SLAVE_MEM_RAND_WAIT_EN
  // Room for WAIT_STATES (max 15) plus LFSR extra (max 3).
  localparam int unsigned CntW = 5;
`else
  localparam int unsigned CntW = 4;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [MEM_DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                        win_q, win_d;
  logic                        we_q, we_d;
  logic [NumBytes-1:0]         sel_q, sel_d;
  logic [WB_DATA_WIDTH-1:0]    wdat_q, wdat_d;
  logic                        ack_q, ack_d;
  logic                        err_q, err_d;
  logic [WB_DATA_WIDTH-1:0]    rdat_q, rdat_d;

  logic [WB_DATA_WIDTH-1:0]    mem_q [Depth];

  logic                        req;
  logic                        adr_win;
  logic [MEM_DEPTH_LOG2-1:0]   adr_idx;
  logic [CntW-1:0]             total_waits;
  logic                        enter_resp;
  logic                        mem_we;

  // Request attributes used on the edge entering RESP: live inputs when
  // going straight from IDLE, latched copies when coming from WAIT.
  logic [MEM_DEPTH_LOG2-1:0]   cur_idx;
  logic                        cur_win;
  logic                        cur_we;
  logic [NumBytes-1:0]         cur_sel;
  logic [WB_DATA_WIDTH-1:0]    cur_wdat;

  assign req     = CYC && STB;
  assign adr_win = (ADR & WinMask) == BASE_ADDR;
  assign adr_idx = ADR[WinBits-1:Bl];

`ifdef WB_SLAVE_MEM_RAND_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_next;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_next   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign total_waits = CntW'(WAIT_STATES) + CntW'(lfsr_q[1:0]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign total_waits = CntW'(WAIT_STATES);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    win_d      = win_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    enter_resp = 1'b0;
    cur_idx    = idx_q;
    cur_win    = win_q;
    cur_we     = we_q;
    cur_sel    = sel_q;
    cur_wdat   = wdat_q;
`ifdef WB_SLAVE_MEM_RAND_WAIT_EN
    lfsr_d     = lfsr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d    = adr_idx;
          win_d    = adr_win;
          we_d     = WE;
          sel_d    = SEL;
          wdat_d   = DAT_W;
          cur_idx  = adr_idx;
          cur_win  = adr_win;
          cur_we   = WE;
          cur_sel  = SEL;
          cur_wdat = DAT_W;
`ifdef WB_SLAVE_MEM_RAND_WAIT_EN
          lfsr_d   = lfsr_next;
`endif
          if (total_waits == '0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = total_waits - CntW'(1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Master withdrawing the request abandons the access silently.
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ack_d  = enter_resp && cur_win;
    err_d  = enter_resp && !cur_win;
    mem_we = enter_resp && cur_we && cur_win;

    rdat_d = rdat_q;
    if (enter_resp && !cur_we) begin
      rdat_d = cur_win ? mem_q[cur_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Memory has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (cur_sel[b]) begin
          mem_q[cur_idx][8*b +: 8] <= cur_wdat[8*b +: 8];
        end
      end
    end
  end

  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign DAT_R = rdat_q;

endmodule

// File: tb/tb_wb_slave_mem_bfm.sv
// Self-checking bench for wb_slave_mem_bfm. Four instances with different
// wait-state / window configurations share the address/data/WE/SEL and reset
// nets; each has its own CYC/STB so only the targeted instance responds.
module tb_wb_slave_mem_bfm;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        we;
  logic [3:0]  sel;
  logic [3:0]  cyc_v;
  logic [3:0]  stb_v;
  logic [3:0]  ack_v;
  logic [3:0]  err_v;
  logic [31:0] dat_r_v [4];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // 0: WS=0, base 0, 1K words
  wb_slave_mem_bfm #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_LOG2(10),
                     .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r_v[0]),
    .CYC(cyc_v[0]), .STB(stb_v[0]), .WE(we), .SEL(sel), .ACK(ack_v[0]), .ERR(err_v[0]));

  // 1: WS=3
  wb_slave_mem_bfm #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_LOG2(10),
                     .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r_v[1]),
    .CYC(cyc_v[1]), .STB(stb_v[1]), .WE(we), .SEL(sel), .ACK(ack_v[1]), .ERR(err_v[1]));

  // 2: small window at 0x1000 (16 words), WS=1
  wb_slave_mem_bfm #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_LOG2(4),
                     .BASE_ADDR(32'h1000), .WAIT_STATES(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r_v[2]),
    .CYC(cyc_v[2]), .STB(stb_v[2]), .WE(we), .SEL(sel), .ACK(ack_v[2]), .ERR(err_v[2]));

  // 3: WS=4, used for abort and reset-in-WAIT
  wb_slave_mem_bfm #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_LOG2(10),
                     .BASE_ADDR(32'h0), .WAIT_STATES(4)) u_dut3 (
    .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r_v[3]),
    .CYC(cyc_v[3]), .STB(stb_v[3]), .WE(we), .SEL(sel), .ACK(ack_v[3]), .ERR(err_v[3]));

  typedef struct packed {
    logic [1:0]  dut;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        exp_err;
    logic [31:0] exp_dat;  // DAT_R during the response (held value for writes)
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs [NumVec];

  function automatic int ws_of(input logic [1:0] d);
    case (d)
      2'd0:    return 0;
      2'd1:    return 3;
      2'd2:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] d, input logic w, input logic [31:0] a,
                              input logic [31:0] dat, input logic [3:0] s, input logic e,
                              input logic [31:0] x);
    vec_t v;
    v.dut = d; v.w = w; v.a = a; v.d = dat; v.s = s; v.exp_err = e; v.exp_dat = x;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One bus access; lat counts rising edges from STB sample to ACK/ERR seen.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, output int lat, output logic g_ack,
                      output logic g_err, output logic [31:0] g_dat, output logic g_drop);
    @(negedge clk);
    adr = a; dat_w = dat; we = w; sel = s;
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
    lat = 0; g_ack = 1'b0; g_err = 1'b0; g_dat = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_v[d] || err_v[d]) begin
        lat = n; g_ack = ack_v[d]; g_err = err_v[d]; g_dat = dat_r_v[d];
        break;
      end
    end
    cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
    @(negedge clk);
    g_drop = !(ack_v[d] || err_v[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic        g_ack, g_err, g_drop, seen;
    logic [31:0] g_dat;

    vecs[0]  = mk(2'd0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    vecs[1]  = mk(2'd0, 1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(2'd0, 1'b1, 32'h20,   32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF);
    vecs[3]  = mk(2'd0, 1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 1'b0, 32'hDEADBEEF);
    vecs[4]  = mk(2'd0, 1'b0, 32'h20,   32'h0,        4'hF, 1'b0, 32'h11BB33DD);
    vecs[5]  = mk(2'd0, 1'b1, 32'h24,   32'h01234567, 4'hF, 1'b0, 32'h11BB33DD);
    vecs[6]  = mk(2'd0, 1'b1, 32'h24,   32'hCAFEF00D, 4'h0, 1'b0, 32'h11BB33DD);
    vecs[7]  = mk(2'd0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'h01234567);
    vecs[8]  = mk(2'd0, 1'b0, 32'h13,   32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
    vecs[9]  = mk(2'd0, 1'b0, 32'h1010, 32'h0,        4'hF, 1'b1, 32'h0);
    vecs[10] = mk(2'd0, 1'b1, 32'hFFC,  32'h87654321, 4'hF, 1'b0, 32'h0);
    vecs[11] = mk(2'd0, 1'b0, 32'hFFC,  32'h0,        4'hF, 1'b0, 32'h87654321);
    vecs[12] = mk(2'd1, 1'b1, 32'h10,   32'h12345678, 4'hF, 1'b0, 32'h0);
    vecs[13] = mk(2'd1, 1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 32'h12345678);
    vecs[14] = mk(2'd2, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 1'b0, 32'h0);
    vecs[15] = mk(2'd2, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    vecs[16] = mk(2'd2, 1'b0, 32'h2000, 32'h0,        4'hF, 1'b1, 32'h0);
    vecs[17] = mk(2'd2, 1'b0, 32'h1000, 32'h0,        4'hF, 1'b0, 32'h55AA55AA);
    vecs[18] = mk(2'd2, 1'b1, 32'h103C, 32'h0F0F0F0F, 4'hF, 1'b0, 32'h55AA55AA);
    vecs[19] = mk(2'd2, 1'b0, 32'h1040, 32'h0,        4'hF, 1'b1, 32'h0);
    vecs[20] = mk(2'd2, 1'b0, 32'h103C, 32'h0,        4'hF, 1'b0, 32'h0F0F0F0F);
    vecs[21] = mk(2'd3, 1'b1, 32'h30,   32'hA5A5A5A5, 4'hF, 1'b0, 32'h0);
    vecs[22] = mk(2'd3, 1'b0, 32'h30,   32'h0,        4'hF, 1'b0, 32'hA5A5A5A5);

    rstn = 1'b0; adr = '0; dat_w = '0; we = 1'b0; sel = '0;
    cyc_v = '0; stb_v = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_ack%0d", d), {31'b0, ack_v[d]}, 32'h0);
      check($sformatf("reset_err%0d", d), {31'b0, err_v[d]}, 32'h0);
      check($sformatf("reset_datr%0d", d), dat_r_v[d], 32'h0);
    end
    rstn = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      xfer(int'(vecs[i].dut), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s,
           lat, g_ack, g_err, g_dat, g_drop);
      check($sformatf("v%0d_ack", i), {31'b0, g_ack}, {31'b0, !vecs[i].exp_err});
      check($sformatf("v%0d_err", i), {31'b0, g_err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, 1 + ws_of(vecs[i].dut));
      check($sformatf("v%0d_datr", i), g_dat, vecs[i].exp_dat);
      check($sformatf("v%0d_one_cycle", i), {31'b0, g_drop}, 32'h1);
    end

    // Abort: drop CYC two cycles into a 4-wait-state write.
    @(negedge clk);
    adr = 32'h30; dat_w = 32'hDEAD0000; we = 1'b1; sel = 4'hF;
    cyc_v[3] = 1'b1; stb_v[3] = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= ack_v[3] | err_v[3];
    end
    cyc_v[3] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= ack_v[3] | err_v[3];
    end
    stb_v[3] = 1'b0;
    check("abort_no_resp", {31'b0, seen}, 32'h0);
    xfer(3, 1'b0, 32'h30, 32'h0, 4'hF, lat, g_ack, g_err, g_dat, g_drop);
    check("abort_rd_ack", {31'b0, g_ack}, 32'h1);
    check("abort_rd_latency", lat, 5);
    check("abort_rd_data", g_dat, 32'hA5A5A5A5);

    // Reset for one cycle while a write sits in WAIT.
    @(negedge clk);
    adr = 32'h30; dat_w = 32'h11111111; we = 1'b1; sel = 4'hF;
    cyc_v[3] = 1'b1; stb_v[3] = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rstwait_ack", {31'b0, ack_v[3]}, 32'h0);
    check("rstwait_err", {31'b0, err_v[3]}, 32'h0);
    check("rstwait_datr", dat_r_v[3], 32'h0);
    rstn = 1'b1;
    cyc_v[3] = 1'b0; stb_v[3] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack_v[3] | err_v[3];
    end
    check("rstwait_no_resp", {31'b0, seen}, 32'h0);
    xfer(3, 1'b0, 32'h30, 32'h0, 4'hF, lat, g_ack, g_err, g_dat, g_drop);
    check("rstwait_rd_ack", {31'b0, g_ack}, 32'h1);
    check("rstwait_rd_latency", lat, 5);
    check("rstwait_rd_data", g_dat, 32'hA5A5A5A5);
    check("rstwait_rd_one_cycle", {31'b0, g_drop}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
